dispatch_buf4: RTL and testbench

Four-wide dispatch holding buffer between rename and the two-lane issue queue. It captures one renamed group of four instructions per cycle and holds up to two groups while the issue queue is stalled. While a group waits, it keeps each operand's ready bit current from the four writeback destinations and clears the valid bit of any instruction killed by a branch. It then presents the oldest group and its shift/enable pulse to the queue.

---
 rtl/dispatch_buf4.sv | 151 +++++++++++++++
 tb/tb_dispatch_buf4.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_buf4.sv
// Four-wide dispatch holding buffer: a 2-group FIFO between rename and the issue queue,
// with wakeup/kill on held groups. Optional same-cycle bypass when empty: DISPATCH_BYPASS_EN.
module dispatch_buf4 #(
  parameter int SIZE      = 32,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WIDTH-1:0]       i_inst1,
  input  logic [WIDTH-1:0]       i_inst2,
  input  logic [WIDTH-1:0]       i_inst3,
  input  logic [WIDTH-1:0]       i_inst4,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_inst1,
  output logic [WIDTH-1:0]       o_inst2,
  output logic [WIDTH-1:0]       o_inst3,
  output logic [WIDTH-1:0]       o_inst4,
  output logic                   o_en,
  input  logic                   i_qready,
  input  logic [4*WIDTH_REG-1:0] i_wdest4x,
  input  logic [WIDTH_BRM-1:0]   i_BrKill,
  input  logic                   i_flush
);

  localparam int RS2_LSB = 3;
  localparam int RS1_LSB = 3 + WIDTH_REG;
  localparam int BRM_LSB = 3 + 3*WIDTH_REG + WIDTH_TAG;

  // The issue queue must at least be able to hold one full group.
  if (SIZE < 4) begin : g_size_check
    $error("dispatch_buf4: SIZE must be at least 4");
  end

  // Sets operand ready bits from non-zero writeback destinations and drops valid on a kill.
  function automatic logic [WIDTH-1:0] wake_kill(
    input logic [WIDTH-1:0]       word,
    input logic [4*WIDTH_REG-1:0] dest,
    input logic [WIDTH_BRM-1:0]   kill
  );
    logic [WIDTH-1:0]     res;
    logic [WIDTH_REG-1:0] d;
    res = word;
    for (int k = 0; k < 4; k++) begin
      d = dest[k*WIDTH_REG +: WIDTH_REG];
      if (d != '0) begin
        if (word[RS1_LSB +: WIDTH_REG] == d) res[2] = 1'b1;
        if (word[RS2_LSB +: WIDTH_REG] == d) res[1] = 1'b1;
      end
    end
    if ((word[BRM_LSB +: WIDTH_BRM] & kill) != '0) res[0] = 1'b0;
    return res;
  endfunction

  logic [WIDTH-1:0] slot_q   [2][4];
  logic [WIDTH-1:0] slot_upd [2][4];
  logic [WIDTH-1:0] in_grp   [4];
  logic [WIDTH-1:0] in_upd   [4];
  logic [WIDTH-1:0] out_grp  [4];
  logic [1:0]       count;
  logic             head;
  logic             tail;
  logic             ready;
  logic             bypass;
  logic             push;
  logic             pop;

  always_comb begin
    in_grp[0] = i_inst1;
    in_grp[1] = i_inst2;
    in_grp[2] = i_inst3;
    in_grp[3] = i_inst4;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_upd[k] = wake_kill(in_grp[k], i_wdest4x, i_BrKill);
      for (int e = 0; e < 2; e++) begin
        slot_upd[e][k] = wake_kill(slot_q[e][k], i_wdest4x, i_BrKill);
      end
    end
  end

  // Ready looks only at registered occupancy so there is no path from i_qready.
  assign ready = (count < 2'd2);

`ifdef DISPATCH_BYPASS_EN
  assign bypass = (count == 2'd0) & i_valid & i_qready & ~i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (count != 2'd0) & i_qready;
  assign push = i_valid & ready & ~i_flush & ~bypass;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (i_flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (pop)  head <= ~head;
      if (push) tail <= ~tail;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Held groups track wakeup/kill every cycle; the free tail slot takes the new group.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int e = 0; e < 2; e++) begin
        for (int k = 0; k < 4; k++) begin
          slot_q[e][k] <= '0;
        end
      end
    end else begin
      for (int e = 0; e < 2; e++) begin
        for (int k = 0; k < 4; k++) begin
          if (push && (tail == 1'(e))) slot_q[e][k] <= in_upd[k];
          else                         slot_q[e][k] <= slot_upd[e][k];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_grp[k] = '0;
    end
    if (bypass) begin
      for (int k = 0; k < 4; k++) out_grp[k] = in_upd[k];
    end else if (count != 2'd0) begin
      for (int k = 0; k < 4; k++) out_grp[k] = slot_upd[head][k];
    end
  end

  assign o_inst1 = out_grp[0];
  assign o_inst2 = out_grp[1];
  assign o_inst3 = out_grp[2];
  assign o_inst4 = out_grp[3];
  assign o_ready = ready;
  assign o_en    = pop | bypass;

endmodule

// File: tb/tb_dispatch_buf4.sv
// Self-checking bench for dispatch_buf4: queue-based model compared every cycle,
// plus directed literal checks. Honours DISPATCH_BYPASS_EN when defined.
module tb_dispatch_buf4;

  localparam int WR = 5;
  localparam int WT = 5;
  localparam int WB = 3;
  localparam int W  = 7 + WB + WT + 3*WR + 3;

  typedef logic [W-1:0]   word_t;
  typedef logic [4*W-1:0] grp_t;

`ifdef DISPATCH_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  word_t       inst1, inst2, inst3, inst4;
  logic        valid;
  logic        ready;
  word_t       out1, out2, out3, out4;
  logic        en;
  logic        qready;
  logic [19:0] wdest;
  logic [2:0]  brkill;
  logic        flush;

  int errors = 0;
  int checks = 0;

  dispatch_buf4 dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inst1(inst1), .i_inst2(inst2), .i_inst3(inst3), .i_inst4(inst4),
    .i_valid(valid), .o_ready(ready),
    .o_inst1(out1), .o_inst2(out2), .o_inst3(out3), .o_inst4(out4),
    .o_en(en), .i_qready(qready), .i_wdest4x(wdest), .i_BrKill(brkill), .i_flush(flush)
  );

  always #5 clk = ~clk;

  function automatic word_t mk(input logic [6:0] uop, input logic [2:0] brm, input logic [4:0] tag,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] st);
    return {uop, brm, tag, rd, rs1, rs2, st};
  endfunction

  // Rule-level model of one instruction seeing this cycle's writebacks and kill mask.
  function automatic word_t model_wk(input word_t w, input logic [19:0] dests, input logic [2:0] kill);
    logic [4:0] rs1, rs2, d;
    logic [2:0] brm;
    bit r1, r2, v;
    rs1 = w[12:8];
    rs2 = w[7:3];
    brm = w[25:23];
    r1 = w[2];
    r2 = w[1];
    v  = w[0];
    for (int k = 0; k < 4; k++) begin
      d = dests[k*5 +: 5];
      if (d != 0 && d == rs1) r1 = 1'b1;
      if (d != 0 && d == rs2) r2 = 1'b1;
    end
    if ((brm & kill) != 0) v = 1'b0;
    return {w[W-1:3], r1, r2, v};
  endfunction

  function automatic grp_t wk_grp(input grp_t g, input logic [19:0] dests, input logic [2:0] kill);
    grp_t r;
    for (int k = 0; k < 4; k++) r[k*W +: W] = model_wk(g[k*W +: W], dests, kill);
    return r;
  endfunction

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input grp_t g, input bit q, input logic [19:0] wd,
                               input logic [2:0] kill, input bit fl);
    @(posedge clk);
    #1;
    valid  = v;
    {inst4, inst3, inst2, inst1} = g;
    qready = q;
    wdest  = wd;
    brkill = kill;
    flush  = fl;
    #3;
  endtask

  grp_t mq[$];

  // Model state advance: held groups age by wakeup/kill, then flush or pop/push.
  always @(posedge clk or negedge rst_n) begin
    int   n;
    bit   byp, do_pop, do_push;
    grp_t incoming;
    if (!rst_n) begin
      mq.delete();
    end else begin
      n        = mq.size();
      incoming = {inst4, inst3, inst2, inst1};
      byp      = BYPASS_ON && n == 0 && valid && qready && !flush;
      do_pop   = n != 0 && qready;
      do_push  = valid && n < 2 && !byp;
      foreach (mq[i]) mq[i] = wk_grp(mq[i], wdest, brkill);
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(wk_grp(incoming, wdest, brkill));
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    grp_t exp_g;
    bit   exp_en, byp;
    if (rst_n) begin
      byp    = BYPASS_ON && mq.size() == 0 && valid && qready && !flush;
      exp_g  = '0;
      exp_en = 1'b0;
      if (byp) begin
        exp_g  = wk_grp({inst4, inst3, inst2, inst1}, wdest, brkill);
        exp_en = 1'b1;
      end else if (mq.size() != 0) begin
        exp_g  = wk_grp(mq[0], wdest, brkill);
        exp_en = qready;
      end
      checkOutput("cmp_ready", W'(ready), W'(mq.size() < 2));
      checkOutput("cmp_en",    W'(en),    W'(exp_en));
      checkOutput("cmp_inst1", out1, exp_g[0*W +: W]);
      checkOutput("cmp_inst2", out2, exp_g[1*W +: W]);
      checkOutput("cmp_inst3", out3, exp_g[2*W +: W]);
      checkOutput("cmp_inst4", out4, exp_g[3*W +: W]);
    end
  end

  grp_t  grp_a, grp_b;
  word_t snap;

  initial begin
    grp_a = {mk(7'h14, 3'b000, 5'd4, 5'd2, 5'd3, 5'd4, 3'b001),
             mk(7'h13, 3'b000, 5'd3, 5'd2, 5'd3, 5'd4, 3'b001),
             mk(7'h12, 3'b010, 5'd2, 5'd2, 5'd3, 5'd4, 3'b001),
             mk(7'h11, 3'b000, 5'd1, 5'd2, 5'd3, 5'd4, 3'b001)};
    grp_b = {mk(7'h24, 3'b100, 5'd8, 5'd9, 5'd6, 5'd7, 3'b001),
             mk(7'h23, 3'b100, 5'd7, 5'd9, 5'd6, 5'd7, 3'b001),
             mk(7'h22, 3'b100, 5'd6, 5'd9, 5'd6, 5'd7, 3'b001),
             mk(7'h21, 3'b100, 5'd5, 5'd9, 5'd6, 5'd7, 3'b001)};
    rst_n = 1'b0;
    {inst4, inst3, inst2, inst1} = '0;
    valid = 0; qready = 0; wdest = '0; brkill = '0; flush = 0;
    #2;
    checkOutput("reset_ready", W'(ready), W'(1));
    checkOutput("reset_en", W'(en), '0);
    checkOutput("reset_inst1", out1, '0);
    checkOutput("reset_inst4", out4, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single group with the queue ready.
    applyStimulus(1, grp_a, 1, '0, '0, 0);
`ifdef DISPATCH_BYPASS_EN
    checkOutput("byp_en", W'(en), W'(1));
    checkOutput("byp_inst1", out1, 33'h0_4404_4321);
`else
    checkOutput("push_en", W'(en), '0);
`endif
    applyStimulus(0, '0, 1, '0, '0, 0);
`ifdef DISPATCH_BYPASS_EN
    checkOutput("after_byp_en", W'(en), '0);
`else
    checkOutput("lat_en", W'(en), W'(1));
    checkOutput("lat_inst1", out1, 33'h0_4404_4321);
    checkOutput("lat_inst2", out2, 33'h0_4908_4321);
`endif
    applyStimulus(0, '0, 1, '0, '0, 0);
    checkOutput("empty_en", W'(en), '0);
    checkOutput("empty_inst1", out1, '0);

    // Fill to two groups while stalled, then drain in order.
    applyStimulus(1, grp_a, 0, '0, '0, 0);
    checkOutput("fill0_ready", W'(ready), W'(1));
    applyStimulus(1, grp_b, 0, '0, '0, 0);
    checkOutput("fill1_ready", W'(ready), W'(1));
    applyStimulus(0, '0, 1, '0, '0, 0);
    checkOutput("full_ready", W'(ready), '0);
    checkOutput("drain_a_en", W'(en), W'(1));
    checkOutput("drain_a_inst1", out1, 33'h0_4404_4321);
    applyStimulus(0, '0, 1, '0, '0, 0);
    checkOutput("drain_b_ready", W'(ready), W'(1));
    snap = out1;
    checkOutput("drain_b_uop", W'(snap[W-1 -: 7]), W'(7'h21));
    applyStimulus(0, '0, 0, '0, '0, 0);
    checkOutput("drained_inst1", out1, '0);

    // Wakeup and kill on a held group.
    applyStimulus(1, grp_a, 0, '0, '0, 0);
    applyStimulus(0, '0, 0, 20'd3 << 10, '0, 0);
    checkOutput("wake_same", out1, 33'h0_4404_4325);
    applyStimulus(0, '0, 0, '0, '0, 0);
    checkOutput("wake_held", out1, 33'h0_4404_4325);
    applyStimulus(0, '0, 0, 20'd4, '0, 0);
    checkOutput("wake_rs2", out4, 33'h0_5010_4327);
    applyStimulus(0, '0, 0, '0, 3'b010, 0);
    checkOutput("kill_same", out2, 33'h0_4908_4326);
    checkOutput("kill_other1", out1, 33'h0_4404_4327);
    applyStimulus(0, '0, 0, '0, '0, 0);
    checkOutput("kill_held", out2, 33'h0_4908_4326);
    checkOutput("kill_other3", out3, 33'h0_4C0C_4327);
    applyStimulus(0, '0, 1, '0, '0, 0);
    checkOutput("kill_drain_en", W'(en), W'(1));

    // Flush at full occupancy suppresses the concurrent push.
    applyStimulus(1, grp_a, 0, '0, '0, 0);
    applyStimulus(1, grp_b, 0, '0, '0, 0);
    applyStimulus(1, grp_a, 0, '0, '0, 1);
    checkOutput("flush_full_ready", W'(ready), '0);
    applyStimulus(0, '0, 0, '0, '0, 0);
    checkOutput("flush_ready", W'(ready), W'(1));
    checkOutput("flush_inst1", out1, '0);
    checkOutput("flush_en", W'(en), '0);

    // Push and pop together at one group, then asynchronous reset mid-stream.
    applyStimulus(1, grp_a, 0, '0, '0, 0);
    applyStimulus(1, grp_b, 1, '0, '0, 0);
    checkOutput("pp_en", W'(en), W'(1));
    checkOutput("pp_inst1", out1, 33'h0_4404_4321);
    applyStimulus(0, '0, 0, '0, '0, 0);
    checkOutput("pp_ready", W'(ready), W'(1));
    snap = out1;
    checkOutput("pp_uop", W'(snap[W-1 -: 7]), W'(7'h21));
    applyStimulus(1, grp_a, 1, '0, '0, 0);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", W'(ready), W'(1));
    checkOutput("arst_en", W'(en), '0);
    checkOutput("arst_inst1", out1, '0);
    checkOutput("arst_inst2", out2, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, '0, 0, '0, '0, 0);
    checkOutput("post_rst_inst1", out1, '0);

    // Mixed traffic exercised against the model.
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i % 3) != 2, (i % 2) ? grp_a : grp_b, (i % 4) != 0,
                    (i % 5 == 1) ? {5'd7, 5'd0, 5'd3, 5'd6} : 20'(i % 8),
                    (i % 6 == 3) ? 3'b100 : 3'b000, i == 11);
    end
    applyStimulus(0, '0, 1, '0, '0, 0);
    applyStimulus(0, '0, 1, '0, '0, 0);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
